// File: rtl/i2c_target_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_target_port
//  Purpose  : I2C target emulating a PCF8574-style 8-bit I/O expander.
//             Write bytes land on o_port; reads return i_port. SCL/SDA are
//             oversampled by clk; SDA is driven open-drain via o_sda_low.
//  Ports    : clk, reset_p (async, active-high)
//             i_scl, i_sda  - raw bus lines (asynchronous)
//             o_sda_low     - 1 = pull SDA low, 0 = release
//             i_port        - byte returned on read transfers
//             o_port        - last byte written by the master
//             o_wr_valid    - one-clk pulse when o_port updates
//             o_busy        - high from address ACK until STOP or NACK
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_target_port #(
  parameter logic [6:0] ADDR       = 7'h27,
  parameter logic [7:0] PORT_RESET = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_low,
  input  logic [7:0] i_port,
  output logic [7:0] o_port,
  output logic       o_wr_valid,
  output logic       o_busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ADDR_ACK  = 3'd2;
  localparam logic [2:0] S_WRITE     = 3'd3;
  localparam logic [2:0] S_WRITE_ACK = 3'd4;
  localparam logic [2:0] S_READ      = 3'd5;
  localparam logic [2:0] S_READ_ACK  = 3'd6;
  localparam logic [2:0] S_IGNORE    = 3'd7;

  // [0],[1] are the synchroniser pair, [2] is the edge-detect history
  logic [2:0] scl_sync_q, sda_sync_q;

  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  // Second-phase flag inside the ACK states (ACK driven / master ACK seen)
  logic       ack_on_q, ack_on_d;
  logic       sda_low_q, sda_low_d;
  logic [7:0] port_q, port_d;
  logic       wr_pend_q, wr_pend_d;
  logic       wr_valid_q, wr_valid_d;

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;
  logic [7:0] w_shift_in;

  assign w_sda      = sda_sync_q[1];
  assign w_scl_rise =  scl_sync_q[1] & ~scl_sync_q[2];
  assign w_scl_fall = ~scl_sync_q[1] &  scl_sync_q[2];
  assign w_start    = scl_sync_q[1] & scl_sync_q[2] &  sda_sync_q[2] & ~sda_sync_q[1];
  assign w_stop     = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] &  sda_sync_q[1];
  assign w_shift_in = {shift_q[6:0], w_sda};

  // State and datapath registers
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      rw_q       <= 1'b0;
      ack_on_q   <= 1'b0;
      sda_low_q  <= 1'b0;
      port_q     <= PORT_RESET;
      wr_pend_q  <= 1'b0;
      wr_valid_q <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], i_scl};
      sda_sync_q <= {sda_sync_q[1:0], i_sda};
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      ack_on_q   <= ack_on_d;
      sda_low_q  <= sda_low_d;
      port_q     <= port_d;
      wr_pend_q  <= wr_pend_d;
      wr_valid_q <= wr_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    ack_on_d   = ack_on_q;
    sda_low_d  = sda_low_q;
    port_d     = port_q;
    wr_pend_d  = 1'b0;
    wr_valid_d = 1'b0;

    // A completed write byte is committed one clk after its 8th SCL rise;
    // shift_q is stable in that clk because no other SCL edge can occur.
    if (wr_pend_q) begin
      port_d     = shift_q;
      wr_valid_d = 1'b1;
    end

    if (w_start) begin
      state_d   = S_ADDR;
      bit_cnt_d = 3'd0;
      sda_low_d = 1'b0;
      ack_on_d  = 1'b0;
    end else if (w_stop) begin
      state_d   = S_IDLE;
      sda_low_d = 1'b0;
      ack_on_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR: begin
          if (w_scl_rise) begin
            shift_d   = w_shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (w_shift_in[7:1] == ADDR) begin
                state_d  = S_ADDR_ACK;
                rw_d     = w_sda;
                ack_on_d = 1'b0;
              end else begin
                state_d = S_IGNORE;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (!ack_on_q) begin
              sda_low_d = 1'b1;
              ack_on_d  = 1'b1;
            end else begin
              ack_on_d  = 1'b0;
              bit_cnt_d = 3'd0;
              if (rw_q) begin
                shift_d   = i_port;
                sda_low_d = ~i_port[7];
                state_d   = S_READ;
              end else begin
                sda_low_d = 1'b0;
                state_d   = S_WRITE;
              end
            end
          end
        end
        S_WRITE: begin
          if (w_scl_rise) begin
            shift_d   = w_shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              wr_pend_d = 1'b1;
              ack_on_d  = 1'b0;
              state_d   = S_WRITE_ACK;
            end
          end
        end
        S_WRITE_ACK: begin
          if (w_scl_fall) begin
            if (!ack_on_q) begin
              sda_low_d = 1'b1;
              ack_on_d  = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              ack_on_d  = 1'b0;
              bit_cnt_d = 3'd0;
              state_d   = S_WRITE;
            end
          end
        end
        S_READ: begin
          // shift_q[7] is the bit currently on the bus
          if (w_scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_low_d = 1'b0;
              ack_on_d  = 1'b0;
              state_d   = S_READ_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_low_d = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        S_READ_ACK: begin
          if (w_scl_rise) begin
            if (w_sda) state_d  = S_IGNORE;
            else       ack_on_d = 1'b1;
          end else if (w_scl_fall && ack_on_q) begin
            shift_d   = i_port;
            sda_low_d = ~i_port[7];
            bit_cnt_d = 3'd0;
            ack_on_d  = 1'b0;
            state_d   = S_READ;
          end
        end
        S_IGNORE: sda_low_d = 1'b0;
        default:  state_d   = S_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    o_sda_low  = sda_low_q;
    o_port     = port_q;
    o_wr_valid = wr_valid_q;
    case (state_q)
      S_ADDR_ACK:                                   o_busy = ack_on_q;
      S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK:     o_busy = 1'b1;
      default:                                      o_busy = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_target_port
//  Purpose  : Self-checking bench for i2c_target_port. A bus-level master
//             drives directed and random transactions; expected responses
//             go into a scoreboard drained by an independent monitor.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_target_port;

  localparam logic [6:0] ADDR = 7'h27;
  localparam time        QTR  = 100ns;   // quarter SCL period

  logic       clk = 1'b0;
  logic       reset_p;
  logic       m_scl, m_sda;
  logic       sda_bus;
  logic       o_sda_low;
  logic [7:0] i_port;
  logic [7:0] o_port;
  logic       o_wr_valid;
  logic       o_busy;

  always #5 clk = ~clk;

  // Wired-AND of master and target on the open-drain line
  assign sda_bus = m_sda & ~o_sda_low;

  i2c_target_port dut (
    .clk       (clk),
    .reset_p   (reset_p),
    .i_scl     (m_scl),
    .i_sda     (sda_bus),
    .o_sda_low (o_sda_low),
    .i_port    (i_port),
    .o_port    (o_port),
    .o_wr_valid(o_wr_valid),
    .o_busy    (o_busy)
  );

  typedef struct {
    string       name;
    logic [31:0] v;
  } item_t;

  item_t      exp_q[$];
  item_t      obs_q[$];
  logic [7:0] wr_exp_q[$];
  int         n_vec = 0;
  int         n_mis = 0;
  int         sda_low_cnt = 0;
  logic       prev_wr_valid = 1'b0;
  logic [7:0] model_port;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    item_t e, o;
    logic [7:0] w;
    if (o_sda_low) sda_low_cnt++;
    if (o_wr_valid) begin
      n_vec++;
      if (wr_exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL wr_valid_unexpected: o_port=%02h, no write expected", o_port);
      end else begin
        w = wr_exp_q.pop_front();
        if (o_port !== w) begin
          n_mis++;
          $display("FAIL wr_data: o_port=%02h expected %02h", o_port, w);
        end
      end
      if (prev_wr_valid) begin
        n_vec++;
        n_mis++;
        $display("FAIL wr_valid_width: pulse longer than 1 clk, got 1 expected 0");
      end
    end
    prev_wr_valid = o_wr_valid;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_vec++;
      if (o.v !== e.v) begin
        n_mis++;
        $display("FAIL %s: got %0h expected %0h", e.name, o.v, e.v);
      end
    end
  end

  // ---------------- bus master helpers ----------------
  task automatic push_exp(input string name, input logic [31:0] e);
    item_t it;
    it.name = name; it.v = e;
    exp_q.push_back(it);
  endtask

  task automatic push_obs(input string name, input logic [31:0] a);
    item_t it;
    it.name = name; it.v = a;
    obs_q.push_back(it);
  endtask

  task automatic expect_obs(input string name, input logic [31:0] e, input logic [31:0] a);
    push_exp(name, e);
    push_obs(name, a);
  endtask

  task automatic bit_cycle(input logic b, output logic r);
    m_sda = b;   #QTR;
    m_scl = 1'b1; #QTR;
    r = sda_bus; #QTR;
    m_scl = 1'b0; #QTR;
  endtask

  task automatic start_cond();
    m_sda = 1'b1; #QTR;
    m_scl = 1'b1; #QTR;
    m_sda = 1'b0; #QTR;
    m_scl = 1'b0; #QTR;
  endtask

  task automatic stop_cond();
    m_sda = 1'b0; #QTR;
    m_scl = 1'b1; #QTR;
    m_sda = 1'b1; #QTR;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic exp_ack);
    logic r;
    push_exp("target_ack", {31'd0, exp_ack});
    for (int i = 7; i >= 0; i--) bit_cycle(d[i], r);
    bit_cycle(1'b1, r);
    push_obs("target_ack", {31'd0, ~r});
  endtask

  task automatic recv_byte(input logic [7:0] e, input logic mack, input logic [7:0] nxt);
    logic       r;
    logic [7:0] got;
    push_exp("read_byte", {24'd0, e});
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, r);
      got[i] = r;
    end
    push_obs("read_byte", {24'd0, got});
    i_port = nxt;               // sampled by the target at the end of the ACK bit
    bit_cycle(~mack, r);
  endtask

  // Write transaction: byte k is bytes[31-8k -: 8]
  task automatic write_txn(input logic [6:0] a, input logic [31:0] bytes, input int n);
    logic       hit;
    logic [7:0] d;
    int         low0;
    hit  = (a == ADDR);
    low0 = sda_low_cnt;
    start_cond();
    send_byte({a, 1'b0}, hit);
    expect_obs("busy_after_addr", {31'd0, hit}, {31'd0, o_busy});
    for (int k = 0; k < n; k++) begin
      d = bytes[31-8*k -: 8];
      if (hit) begin
        wr_exp_q.push_back(d);
        model_port = d;
      end
      send_byte(d, hit);
    end
    stop_cond();
    #QTR;
    expect_obs("busy_after_stop", 0, {31'd0, o_busy});
    expect_obs("port_after_write", {24'd0, model_port}, {24'd0, o_port});
    if (!hit) expect_obs("miss_sda_low_cycles", 0, sda_low_cnt - low0);
  endtask

  // Read transaction: master ACKs every byte except the last
  task automatic read_txn(input logic [31:0] bytes, input int n);
    logic [7:0] nxt;
    start_cond();
    i_port = bytes[31:24];
    send_byte({ADDR, 1'b1}, 1'b1);
    expect_obs("busy_in_read", 1, {31'd0, o_busy});
    for (int k = 0; k < n; k++) begin
      nxt = (k < n - 1) ? bytes[31-8*(k+1) -: 8] : 8'($urandom);
      recv_byte(bytes[31-8*k -: 8], (k < n - 1), nxt);
    end
    expect_obs("sda_after_nack", 0, {31'd0, o_sda_low});
    stop_cond();
    #QTR;
    expect_obs("busy_after_read", 0, {31'd0, o_busy});
    expect_obs("port_after_read", {24'd0, model_port}, {24'd0, o_port});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       r;
    logic [6:0] a;
    int         sel, n;
    m_scl = 1'b1; m_sda = 1'b1; i_port = 8'h00; reset_p = 1'b1;
    model_port = 8'hFF;
    repeat (3) @(posedge clk);
    #2 reset_p = 1'b0;
    @(negedge clk);
    expect_obs("reset_sda_low",  0,     {31'd0, o_sda_low});
    expect_obs("reset_port",     8'hFF, {24'd0, o_port});
    expect_obs("reset_wr_valid", 0,     {31'd0, o_wr_valid});
    expect_obs("reset_busy",     0,     {31'd0, o_busy});
    #QTR;

    // Single write, multi-byte write, address miss
    write_txn(ADDR,  32'h0C00_0000, 1);
    write_txn(ADDR,  32'h383C_2800, 3);
    write_txn(7'h3F, 32'h5500_0000, 1);

    // Read two bytes, NACK the second
    read_txn(32'hA53C_0000, 2);

    // Abort mid-byte with a repeated START
    start_cond();
    send_byte(8'h4E, 1'b1);
    for (int i = 0; i < 4; i++) bit_cycle(1'($urandom), r);
    start_cond();
    send_byte(8'h4E, 1'b1);
    wr_exp_q.push_back(8'h81);
    model_port = 8'h81;
    send_byte(8'h81, 1'b1);
    stop_cond();
    #QTR;
    expect_obs("port_after_abort", 8'h81, {24'd0, o_port});

    // Randomised transactions
    repeat (10) begin
      sel = $urandom_range(0, 2);
      n   = $urandom_range(1, 3);
      case (sel)
        0: write_txn(ADDR, $urandom, n);
        1: begin
          a = 7'($urandom);
          if (a == ADDR) a = a ^ 7'h01;
          write_txn(a, $urandom, n);
        end
        default: read_txn($urandom, n);
      endcase
    end

    // Reset while the target drives the address ACK
    start_cond();
    for (int i = 7; i >= 0; i--) bit_cycle(r_bit(8'h4E, i), r);
    m_sda = 1'b1;
    #QTR;
    expect_obs("ack_before_reset", 1, {31'd0, o_sda_low});
    #2 reset_p = 1'b1;
    #1;
    expect_obs("sda_low_in_reset", 0,     {31'd0, o_sda_low});
    expect_obs("port_in_reset",    8'hFF, {24'd0, o_port});
    expect_obs("busy_in_reset",    0,     {31'd0, o_busy});
    model_port = 8'hFF;
    #20 reset_p = 1'b0;
    m_scl = 1'b1; #QTR;
    m_sda = 1'b1; #QTR;
    write_txn(ADDR, 32'h1200_0000, 1);

    #QTR;
    expect_obs("wr_pending_left", 0, wr_exp_q.size());
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  function automatic logic r_bit(input logic [7:0] v, input int i);
    return v[i];
  endfunction

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
